// File: rtl/bullet_hit_scanner.sv
// bullet_hit_scanner: per-frame bullet vs tank collision scanner.
// Snapshots bullets/tanks on frame_start, tests one bullet per cycle, commits hit matrix.
module bullet_hit_scanner #(
    parameter int TANK_NUM    = 2,
    parameter int BULLET_NUM  = 8,
    parameter int TANK_SIZE   = 32,
    parameter int BULLET_SIZE = 4,
    localparam int N  = TANK_NUM * BULLET_NUM,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                                      Clk,
    input  logic                                      Reset_n,
    input  logic                                      frame_start,
    input  logic [TANK_NUM-1:0][BULLET_NUM-1:0][31:0] bullet_array,
    input  logic [TANK_NUM-1:0][9:0]                  tank_x,
    input  logic [TANK_NUM-1:0][9:0]                  tank_y,
    output logic [N-1:0][TANK_NUM-1:0]                hit,
    output logic                                      clear_valid,
    output logic [IW-1:0]                             clear_idx,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overrun
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        COMMIT
    } state_t;

    state_t                     state;
    logic [IW-1:0]              idx;
    logic [N-1:0][20:0]         snap_b;
    logic [TANK_NUM-1:0][9:0]   snap_tx;
    logic [TANK_NUM-1:0][9:0]   snap_ty;
    logic [N-1:0][TANK_NUM-1:0] work;

    logic [20:0]                cur;
    logic [10:0]                bx;
    logic [10:0]                by;
    logic [10:0]                tx;
    logic [10:0]                ty;
    logic [TANK_NUM-1:0]        hit_vec;
    int                         owner;
    logic                       unused_bits;

    // Bits above the y field carry no meaning for collision
    always_comb begin
        unused_bits = 1'b0;
        for (int o = 0; o < TANK_NUM; o++) begin
            for (int b = 0; b < BULLET_NUM; b++) begin
                unused_bits = unused_bits ^ (^bullet_array[o][b][31:21]);
            end
        end
    end

    // Box-overlap test of the current snapshot bullet against every tank
    always_comb begin
        cur     = snap_b[idx];
        bx      = {1'b0, cur[10:1]};
        by      = {1'b0, cur[20:11]};
        owner   = int'(idx) / BULLET_NUM;
        tx      = '0;
        ty      = '0;
        hit_vec = '0;
        for (int j = 0; j < TANK_NUM; j++) begin
            tx = {1'b0, snap_tx[j]};
            ty = {1'b0, snap_ty[j]};
            if (cur[0] && (j != owner)
                && (bx < tx + 11'(TANK_SIZE))
                && (bx + 11'(BULLET_SIZE) > tx)
                && (by < ty + 11'(TANK_SIZE))
                && (by + 11'(BULLET_SIZE) > ty)) begin
                hit_vec[j] = 1'b1;
            end
        end
    end

    // Scan sequencer: snapshot, per-bullet scan, single-cycle commit
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state       <= IDLE;
            idx         <= '0;
            snap_b      <= '0;
            snap_tx     <= '0;
            snap_ty     <= '0;
            work        <= '0;
            hit         <= '0;
            clear_valid <= 1'b0;
            clear_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            clear_valid <= 1'b0;
            done        <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (frame_start) begin
                        for (int o = 0; o < TANK_NUM; o++) begin
                            for (int b = 0; b < BULLET_NUM; b++) begin
                                snap_b[o*BULLET_NUM+b] <= bullet_array[o][b][20:0];
                            end
                        end
                        snap_tx <= tank_x;
                        snap_ty <= tank_y;
                        work    <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    work[idx] <= hit_vec;
                    if (|hit_vec) begin
                        clear_valid <= 1'b1;
                        clear_idx   <= idx;
                    end
                    if (idx == IW'(N - 1)) begin
                        state <= COMMIT;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                    if (frame_start) begin
                        overrun <= 1'b1;
                    end
                end
                COMMIT: begin
                    hit   <= work;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (frame_start) begin
                        overrun <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// tb_bullet_hit_scanner: randomized and directed checks of bullet_hit_scanner
// against a frame-level reference model.
module tb_bullet_hit_scanner;

    localparam int T  = 2;
    localparam int B  = 8;
    localparam int N  = T * B;
    localparam int TS = 32;
    localparam int BS = 4;

    logic                     Clk = 1'b0;
    logic                     Reset_n;
    logic                     frame_start;
    logic [T-1:0][B-1:0][31:0] bullet_array;
    logic [T-1:0][9:0]        tank_x;
    logic [T-1:0][9:0]        tank_y;
    logic [N-1:0][T-1:0]      hit;
    logic                     clear_valid;
    logic [3:0]               clear_idx;
    logic                     busy;
    logic                     done;
    logic                     overrun;

    int checks   = 0;
    int failures = 0;
    int nprint   = 0;
    int done_cnt = 0;
    int clr_cnt  = 0;
    bit cmp_on   = 0;

    bullet_hit_scanner dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .frame_start  (frame_start),
        .bullet_array (bullet_array),
        .tank_x       (tank_x),
        .tank_y       (tank_y),
        .hit          (hit),
        .clear_valid  (clear_valid),
        .clear_idx    (clear_idx),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun)
    );

    always #5 Clk = ~Clk;

    // Reference model: whole-frame hit matrix computed at frame start
    logic [N-1:0][T-1:0] m_work;
    logic [N-1:0][T-1:0] m_hit;
    logic m_cv, m_busy, m_done, m_ovr;
    int   m_ci;
    int   phase;

    function automatic logic [N-1:0][T-1:0] calc_hits();
        logic [N-1:0][T-1:0] r;
        logic [31:0] w;
        int o, bx, by, tx, ty;
        r = '0;
        for (int i = 0; i < N; i++) begin
            o  = i / B;
            w  = bullet_array[o][i % B];
            bx = int'(w[10:1]);
            by = int'(w[20:11]);
            for (int j = 0; j < T; j++) begin
                tx = int'(tank_x[j]);
                ty = int'(tank_y[j]);
                if (w[0] && j != o && bx < tx + TS && bx + BS > tx
                    && by < ty + TS && by + BS > ty)
                    r[i][j] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_step();
        if (!Reset_n) begin
            phase  = -1;
            m_work = '0;
            m_hit  = '0;
            m_cv   = 0;
            m_ci   = 0;
            m_busy = 0;
            m_done = 0;
            m_ovr  = 0;
        end else begin
            m_cv   = 0;
            m_done = 0;
            if (phase < 0) begin
                if (frame_start) begin
                    m_work = calc_hits();
                    phase  = 0;
                    m_busy = 1;
                end
            end else begin
                if (frame_start) m_ovr = 1;
                phase++;
                if (phase <= N) begin
                    if (|m_work[phase-1]) begin
                        m_cv = 1;
                        m_ci = phase - 1;
                    end
                end else begin
                    m_hit  = m_work;
                    m_done = 1;
                    m_busy = 0;
                    phase  = -1;
                end
            end
        end
    endtask

    initial begin
        phase = -1;
        forever begin
            @(posedge Clk);
            model_step();
        end
    end

    // Per-cycle comparison of every output against the model
    initial begin
        bit ok;
        logic [3:0] eci;
        forever begin
            @(negedge Clk);
            if (cmp_on) begin
                eci = m_ci[3:0];
                ok = (hit === m_hit) && (clear_valid === m_cv)
                     && (busy === m_busy) && (done === m_done)
                     && (overrun === m_ovr)
                     && (!m_cv || clear_idx === eci);
                checks++;
                if (!ok) begin
                    failures++;
                    if (nprint < 20) begin
                        nprint++;
                        $display("FAIL cycle_cmp t=%0t hit=%h/%h cv=%b/%b ci=%0d/%0d busy=%b/%b done=%b/%b ovr=%b/%b (actual/required)",
                                 $time, hit, m_hit, clear_valid, m_cv, clear_idx, eci,
                                 busy, m_busy, done, m_done, overrun, m_ovr);
                    end
                end
                if (done) done_cnt++;
                if (clear_valid) clr_cnt++;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic set_b(input int o, input int b, input int act, input int x, input int y);
        bullet_array[o][b] = {11'($urandom), 10'(y), 10'(x), 1'(act)};
    endtask

    task automatic clear_all();
        for (int o = 0; o < T; o++)
            for (int b = 0; b < B; b++)
                set_b(o, b, 0, $urandom_range(0, 1023), $urandom_range(0, 1023));
    endtask

    task automatic randomize_inputs();
        int t, x, y;
        for (int j = 0; j < T; j++) begin
            tank_x[j] = 10'($urandom_range(0, 1000));
            tank_y[j] = 10'($urandom_range(0, 1000));
        end
        for (int o = 0; o < T; o++) begin
            for (int b = 0; b < B; b++) begin
                t = $urandom % T;
                x = int'(tank_x[t]) + $urandom_range(0, 44) - 6;
                y = int'(tank_y[t]) + $urandom_range(0, 44) - 6;
                if (x < 0) x = 0;
                if (x > 1023) x = 1023;
                if (y < 0) y = 0;
                if (y > 1023) y = 1023;
                set_b(o, b, ($urandom % 4) != 0, x, y);
            end
        end
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input int scramble, output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge Clk);
            if (done) begin
                got = 1;
                lat = k;
            end else if (scramble != 0) begin
                randomize_inputs();
                if (scramble > 1) frame_start = ($urandom % 8) == 0;
            end
        end
        frame_start = 1'b0;
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL done_timeout actual=no_done required=done_within_40");
        end
    endtask

    task automatic run_frame(input int scramble);
        int lat;
        pulse();
        wait_done(scramble, lat);
        @(negedge Clk);
    endtask

    initial begin
        int c0, d0, lat;
        Reset_n     = 1'b0;
        frame_start = 1'b0;
        randomize_inputs();
        repeat (2) begin
            @(negedge Clk);
            randomize_inputs();
            frame_start = 1'($urandom);
        end
        chk("reset_outputs", {hit, clear_valid, clear_idx, busy, done, overrun}, '0);
        frame_start = 1'b0;
        Reset_n     = 1'b1;
        cmp_on      = 1;
        @(negedge Clk);

        // basic hit
        clear_all();
        tank_x[0] = 10'd400; tank_y[0] = 10'd400;
        tank_x[1] = 10'd100; tank_y[1] = 10'd100;
        set_b(0, 0, 1, 110, 120);
        c0 = clr_cnt; d0 = done_cnt;
        pulse();
        wait_done(0, lat);
        @(negedge Clk);
        chk("basic_latency", 64'(lat), 64'd16);
        chk("basic_hit", 64'(hit), 64'h2);
        chk("basic_clears", 64'(clr_cnt - c0), 64'd1);
        chk("basic_dones", 64'(done_cnt - d0), 64'd1);
        repeat (5) @(negedge Clk);
        chk("basic_hold", 64'(hit), 64'h2);
        clear_all();
        run_frame(0);
        chk("empty_frame", 64'(hit), 64'h0);

        // self-hit and inactive
        tank_x[0] = 10'd300; tank_y[0] = 10'd300;
        tank_x[1] = 10'd100; tank_y[1] = 10'd100;
        set_b(1, 0, 1, 110, 110);
        set_b(1, 1, 0, 310, 310);
        c0 = clr_cnt;
        run_frame(0);
        chk("self_inactive_hit", 64'(hit), 64'h0);
        chk("self_inactive_clr", 64'(clr_cnt - c0), 64'd0);

        // box edges
        clear_all();
        tank_x[0] = 10'd200; tank_y[0] = 10'd50;
        tank_x[1] = 10'd600; tank_y[1] = 10'd400;
        set_b(1, 0, 1, 232, 60);
        set_b(1, 1, 1, 231, 60);
        set_b(1, 2, 1, 196, 60);
        set_b(1, 3, 1, 197, 60);
        set_b(1, 4, 1, 210, 82);
        set_b(1, 5, 1, 210, 81);
        set_b(1, 6, 1, 210, 46);
        set_b(1, 7, 1, 210, 47);
        c0 = clr_cnt;
        run_frame(0);
        chk("edge_hit", 64'(hit), 64'h4444_0000);
        chk("edge_clears", 64'(clr_cnt - c0), 64'd4);
        clear_all();
        tank_x[1] = 10'd1000; tank_y[1] = 10'd300;
        set_b(0, 0, 1, 1020, 310);
        set_b(0, 1, 1, 1023, 331);
        run_frame(0);
        chk("no_wrap_hit", 64'(hit), 64'hA);

        // randomized frames, inputs churn during the scan
        repeat (12) begin
            randomize_inputs();
            run_frame(1);
        end
        chk("no_overrun_yet", 64'(overrun), 64'd0);

        // overrun
        d0 = done_cnt;
        pulse();
        repeat (4) @(negedge Clk);
        pulse();
        repeat (40) @(negedge Clk);
        chk("overrun_dones", 64'(done_cnt - d0), 64'd1);
        chk("overrun_set", 64'(overrun), 64'd1);
        run_frame(0);
        chk("overrun_sticky", 64'(overrun), 64'd1);

        // reset mid-scan
        clear_all();
        tank_x[0] = 10'd400; tank_y[0] = 10'd400;
        tank_x[1] = 10'd100; tank_y[1] = 10'd100;
        set_b(0, 0, 1, 110, 120);
        run_frame(0);
        chk("pre_reset_hit", 64'(hit), 64'h2);
        pulse();
        repeat (6) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        chk("midscan_hit", 64'(hit), 64'h0);
        chk("midscan_ovr", 64'(overrun), 64'd0);
        d0 = done_cnt;
        repeat (30) @(negedge Clk);
        chk("midscan_nodone", 64'(done_cnt - d0), 64'd0);
        c0 = clr_cnt;
        run_frame(0);
        chk("fresh_hit", 64'(hit), 64'h2);
        chk("fresh_clears", 64'(clr_cnt - c0), 64'd1);

        // random frames with stray frame_start pulses
        repeat (8) begin
            randomize_inputs();
            run_frame(2);
        end
        frame_start = 1'b0;
        repeat (40) @(negedge Clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
